// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the pipeline requesters and the regfile write-port arbiter.
// With REGFILE_WB_ARB_BUSY_EN defined the bus also carries the wb_busy hazard vector.
interface regfile_wb_arbiter_if #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned GPR_SIZE = 5,
  parameter int unsigned NREQ     = 3,
  parameter int unsigned CNT_W    = 64
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*GPR_SIZE-1:0] req_rd;
  logic [NREQ*WIDTH-1:0]    req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     wb_hold;
  logic [GPR_SIZE-1:0]      write_back_rd;
  logic [WIDTH-1:0]         write_back_data;
  logic                     write_back_reg_wen;
  logic [CNT_W-1:0]         wb_count;
`ifdef REGFILE_WB_ARB_BUSY_EN
  logic [31:0]              wb_busy;
`endif

  modport slave (
    input  req_valid, req_rd, req_data, wb_hold,
    output req_ready, write_back_rd, write_back_data, write_back_reg_wen, wb_count
`ifdef REGFILE_WB_ARB_BUSY_EN
    , output wb_busy
`endif
  );

  modport master (
    output req_valid, req_rd, req_data, wb_hold,
    input  req_ready, write_back_rd, write_back_data, write_back_reg_wen, wb_count
`ifdef REGFILE_WB_ARB_BUSY_EN
    , input wb_busy
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port, with registered write-back and a commit counter.
// Optional REGFILE_WB_ARB_BUSY_EN adds a one-hot wb_busy vector of the register being written.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned GPR_SIZE = 5,
  parameter int unsigned NREQ     = 3,
  parameter int unsigned CNT_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]    r_rr_ptr;
  logic [GPR_SIZE-1:0] r_wb_rd;
  logic [WIDTH-1:0]    r_wb_data;
  logic                r_wb_wen;
  logic [CNT_W-1:0]    r_wb_count;

  logic [NREQ-1:0]     w_ready;
  logic [NREQ-1:0]     w_real;
  logic                w_gnt_any;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [GPR_SIZE-1:0] w_gnt_rd;
  logic [WIDTH-1:0]    w_gnt_data;

  // Zero-destination requests are dropped freely; one real request wins, searching after the last grant.
  always_comb begin
    int unsigned v_idx;
    w_ready    = '0;
    w_real     = '0;
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_rd   = '0;
    w_gnt_data = '0;
    v_idx      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_real[i] = bus.req_valid[i] && (bus.req_rd[i*GPR_SIZE +: GPR_SIZE] != '0);
    end
    if (!bus.wb_hold) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && !w_real[i]) w_ready[i] = 1'b1;
      end
      for (int unsigned k = 1; k <= NREQ; k++) begin
        v_idx = (32'(r_rr_ptr) + k) % NREQ;
        if (!w_gnt_any && w_real[v_idx]) begin
          w_gnt_any      = 1'b1;
          w_gnt_idx      = PTR_W'(v_idx);
          w_gnt_rd       = bus.req_rd[v_idx*GPR_SIZE +: GPR_SIZE];
          w_gnt_data     = bus.req_data[v_idx*WIDTH +: WIDTH];
          w_ready[v_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= PTR_W'(NREQ - 1);
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_wen   <= 1'b0;
      r_wb_count <= '0;
    end else begin
      r_wb_wen <= w_gnt_any;
      if (w_gnt_any) begin
        r_rr_ptr   <= w_gnt_idx;
        r_wb_rd    <= w_gnt_rd;
        r_wb_data  <= w_gnt_data;
        r_wb_count <= r_wb_count + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready          = w_ready;
  assign bus.write_back_rd      = r_wb_rd;
  assign bus.write_back_data    = r_wb_data;
  assign bus.write_back_reg_wen = r_wb_wen;
  assign bus.wb_count           = r_wb_count;

`ifdef REGFILE_WB_ARB_BUSY_EN
  logic [31:0] r_wb_busy;

  // Grants always carry a non-zero rd, so bit 0 can never be set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_busy <= '0;
    end else if (w_gnt_any) begin
      r_wb_busy <= 32'(1) << w_gnt_rd;
    end else begin
      r_wb_busy <= '0;
    end
  end

  assign bus.wb_busy = r_wb_busy;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin, zero-destination, hold, mid-stream reset.
module tb_regfile_wb_arbiter;
  localparam int unsigned WIDTH    = 64;
  localparam int unsigned GPR_SIZE = 5;
  localparam int unsigned NREQ     = 3;
  localparam int unsigned CNT_W    = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  regfile_wb_arbiter_if #(.WIDTH(WIDTH), .GPR_SIZE(GPR_SIZE), .NREQ(NREQ), .CNT_W(CNT_W)) u_if ();

  regfile_wb_arbiter #(.WIDTH(WIDTH), .GPR_SIZE(GPR_SIZE), .NREQ(NREQ), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [GPR_SIZE-1:0] rd, input logic [WIDTH-1:0] d);
    u_if.req_valid[i]                   = v;
    u_if.req_rd[i*GPR_SIZE +: GPR_SIZE] = rd;
    u_if.req_data[i*WIDTH +: WIDTH]     = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, '0, '0);
  endtask

  task automatic all_real();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b1, GPR_SIZE'(i + 1), 64'h1000 + 64'(i));
  endtask

  // Check registered outputs one step after the active edge.
  task automatic chk_out(input string tag, input logic wen, input logic [GPR_SIZE-1:0] rd,
                         input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] cnt);
    check_eq({tag, "_wen"}, 64'(u_if.write_back_reg_wen), 64'(wen));
    check_eq({tag, "_rd"}, 64'(u_if.write_back_rd), 64'(rd));
    check_eq({tag, "_data"}, u_if.write_back_data, data);
    check_eq({tag, "_cnt"}, u_if.wb_count, cnt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    u_if.wb_hold = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 chk_out("reset", 1'b0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;

    // Idle: nothing requested, nothing written.
    for (int c = 0; c < 10; c++) begin
      #1 check_eq("idle_ready", 64'(u_if.req_ready), 64'h0);
      @(posedge clk);
      #1 check_eq("idle_wen", 64'(u_if.write_back_reg_wen), 64'h0);
      check_eq("idle_cnt", u_if.wb_count, 64'h0);
      @(negedge clk);
    end

    // Single write to x5.
    set_req(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    #1 check_eq("single_ready", 64'(u_if.req_ready), 64'h1);
    @(posedge clk);
    #1 chk_out("single", 1'b1, 5'd5, 64'hDEAD_BEEF, 64'd1);
`ifdef REGFILE_WB_ARB_BUSY_EN
    check_eq("single_busy", 64'(u_if.wb_busy), 64'h20);
`endif
    @(negedge clk);
    clear_reqs();
    #1 check_eq("single_idle_ready", 64'(u_if.req_ready), 64'h0);
    @(posedge clk);
    #1 chk_out("single_after", 1'b0, 5'd5, 64'hDEAD_BEEF, 64'd1);
`ifdef REGFILE_WB_ARB_BUSY_EN
    check_eq("single_busy_clr", 64'(u_if.wb_busy), 64'h0);
`endif
    @(negedge clk);

    // Reset pulse returns the pointer so requester 0 goes first.
    rst = 1'b1;
    @(posedge clk);
    #1 check_eq("pulse_cnt", u_if.wb_count, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin with all three continuously valid.
    all_real();
    for (int k = 0; k < 6; k++) begin
      int g;
      g = k % 3;
      #1 check_eq("rr_ready", 64'(u_if.req_ready), 64'(1) << g);
      @(posedge clk);
      #1 chk_out("rr", 1'b1, GPR_SIZE'(g + 1), 64'h1000 + 64'(g), 64'(k + 1));
      @(negedge clk);
    end

    // Zero destination on req0 alongside a real write to x7 on req1 (pointer at 2).
    set_req(0, 1'b1, 5'd0, 64'hAAAA);
    set_req(1, 1'b1, 5'd7, 64'h7777);
    set_req(2, 1'b0, 5'd0, 64'h0);
    #1 check_eq("zero_ready", 64'(u_if.req_ready), 64'h3);
    @(posedge clk);
    #1 chk_out("zero", 1'b1, 5'd7, 64'h7777, 64'd7);
`ifdef REGFILE_WB_ARB_BUSY_EN
    check_eq("zero_busy", 64'(u_if.wb_busy), 64'h80);
`endif
    @(negedge clk);
    clear_reqs();
    #1 check_eq("zero_idle_ready", 64'(u_if.req_ready), 64'h0);
    @(posedge clk);
    #1 chk_out("zero_after", 1'b0, 5'd7, 64'h7777, 64'd7);
    @(negedge clk);

    // Hold with everyone valid, including a zero-destination request.
    all_real();
    set_req(0, 1'b1, 5'd0, 64'h1000);
    u_if.wb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check_eq("hold_ready", 64'(u_if.req_ready), 64'h0);
      @(posedge clk);
      #1 chk_out("hold", 1'b0, 5'd7, 64'h7777, 64'd7);
      @(negedge clk);
    end
    all_real();
    u_if.wb_hold = 1'b0;
    // Pointer was 1, so requester 2 goes next.
    #1 check_eq("release_ready", 64'(u_if.req_ready), 64'h4);
    @(posedge clk);
    #1 chk_out("release", 1'b1, 5'd3, 64'h1002, 64'd8);
    @(negedge clk);
    #1 check_eq("wrap_ready", 64'(u_if.req_ready), 64'h1);
    @(posedge clk);
    #1 chk_out("wrap", 1'b1, 5'd1, 64'h1000, 64'd9);
    @(negedge clk);

    // Reset mid-stream with requests still asserted; pointer was 0.
    rst = 1'b1;
    @(posedge clk);
    #1 chk_out("midrst", 1'b0, '0, '0, '0);
`ifdef REGFILE_WB_ARB_BUSY_EN
    check_eq("midrst_busy", 64'(u_if.wb_busy), 64'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    set_req(2, 1'b0, 5'd0, 64'h0);
    #1 check_eq("postrst_ready", 64'(u_if.req_ready), 64'h1);
    @(posedge clk);
    #1 chk_out("postrst", 1'b1, 5'd1, 64'h1000, 64'd1);
    @(negedge clk);
    #1 check_eq("postrst_next_ready", 64'(u_if.req_ready), 64'h2);
    @(posedge clk);
    #1 chk_out("postrst_next", 1'b1, 5'd2, 64'h1001, 64'd2);
    @(negedge clk);
    clear_reqs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
